mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one memory port among NUM_REQ requesters, e.g. instruction fetch, data load/store and debug.
- Grants one requester at a time, drives the shared port request, waits for the memory acknowledge, and returns it to the granted requester.
- Supports locked bursts of up to MAX_BURST back-to-back transactions.
- Index and counter widths come from macros::log_2 at elaboration.

Parameters:
- NUM_REQ, 2, number of requesters (legal: 2 or more).
- MAX_BURST, 4, maximum consecutive transactions one locked requester may hold the port (legal: 1 or more).
- TIMEOUT, 64, cycles in BUSY without mem_ack before abort; used only with ARB_TIMEOUT_EN (legal: 2 or more).
- IDX_W, macros::log_2(NUM_REQ-1), width of grant index; the bit count needed to hold NUM_REQ-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until that requester sees ack.
- lock  in  NUM_REQ  per-requester burst-lock hint; sampled on the mem_ack cycle.
- gnt  out  NUM_REQ  one-hot registered grant.
- gnt_idx  out  IDX_W  binary index of granted requester.
- mem_req  out  1  shared port request, held high through the transaction.
- mem_ack  in  1  shared port completion, single-cycle pulse.
- ack  out  NUM_REQ  combinational: gnt AND mem_ack while BUSY.
- err  out  1  one-cycle timeout abort pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: clk and rst as above; asynchronous, active-high.
  - Asserting rst immediately clears gnt, gnt_idx, mem_req, ack and err, and sets state=IDLE, rr_ptr=0, burst_cnt=0 and wait_cnt=0.
  - Reset mid-transaction drops mem_req at once; the memory side must tolerate the abandoned request.
- States: IDLE, BUSY.
- IDLE:
  - If req is nonzero, pick the first set bit searching upward from rr_ptr, wrapping past NUM_REQ-1 to 0.
  - Next edge: register gnt/gnt_idx, assert mem_req, go to BUSY, burst_cnt=0.
  - Latency from req to mem_req is 1 cycle.
  - If req is zero, stay in IDLE; all outputs 0.
- BUSY:
  - mem_req=1 and gnt is stable.
  - On the cycle mem_ack=1, ack[gnt_idx]=1 combinationally.
  - If lock[gnt_idx]=1 and burst_cnt<MAX_BURST-1: stay in BUSY, keep the grant, burst_cnt+1, mem_req stays high (next transaction back-to-back).
  - Otherwise: go to IDLE next edge, clear gnt and mem_req, set rr_ptr=(gnt_idx+1) mod NUM_REQ.
- Fairness:
  - rr_ptr advances only on release, so a requester that just released has lowest priority.
  - Any continuously requesting requester is granted within (NUM_REQ-1)*MAX_BURST transactions.
- Request dropped during BUSY: a protocol violation. The arbiter ignores it and keeps the grant until mem_ack, then releases normally.
- Requester contract: deasserts req the cycle after its ack.
  - After the one-cycle IDLE pass, the lowest-latency regrant to another requester is 2 cycles after mem_ack.
- mem_ack in IDLE is ignored; ack stays 0.
- MAX_BURST=1 disables lock effectively.
- burst_cnt width is macros::log_2(MAX_BURST) bits.
- rr_ptr arithmetic wraps at NUM_REQ, not at 2^IDX_W, for non-power-of-two NUM_REQ.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - wait_cnt (macros::log_2(TIMEOUT) bits) clears on entry to BUSY and on each mem_ack, and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT-1 with no mem_ack: err=1 for one cycle, ack[gnt_idx]=1 the same cycle (abort completion), release as a non-locked completion (rr_ptr advances).
  - mem_ack arriving on the same cycle as expiry wins: normal completion, err=0.
- Undefined:
  - No wait_cnt; BUSY waits indefinitely; err driven constant 0.

Test Plan:
- Reset/idle: rst pulsed mid-BUSY (NUM_REQ=3, requester 1 granted) -> gnt, mem_req and ack go 0 asynchronously; after release, req=3'b000 keeps all outputs 0.
- Basic grant: req=3'b010 at cycle 0 -> cycle 1 gnt=3'b010, gnt_idx=1, mem_req=1; mem_ack at cycle 3 -> ack=3'b010 at cycle 3, mem_req=0 at cycle 4.
- Round robin: req=3'b111 held, single-cycle mem_ack per grant, no lock -> grant order 0,1,2,0,1 from reset.
- Burst lock: MAX_BURST=4, lock[0]=1, req=3'b011 -> requester 0 gets exactly 4 acks with mem_req continuously high, then gnt switches to requester 1.
- Non-power-of-two wrap: NUM_REQ=3, rr_ptr=2, req=3'b001 -> requester 0 granted; gnt_idx never shows 3.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): grant requester 2, never assert mem_ack -> err and ack[2] pulse on the 8th BUSY cycle; next grant goes to requester 0; without the macro, no err and gnt held for 100 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// A requester is granted, mem_req is held until mem_ack, and the ack is
// routed back to the granted requester. Locked bursts of up to MAX_BURST
// back-to-back transactions keep the grant.
// Optional feature macro: ARB_TIMEOUT_EN adds a BUSY watchdog that aborts a
// transaction after TIMEOUT cycles without mem_ack and pulses err.

package macros;
    // Number of bits needed to hold the given value (at least 1).
    function automatic int log_2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) <= value) begin
            bits++;
        end
        return bits;
    endfunction
endpackage

module mem_port_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 64,
    parameter int IDX_W     = macros::log_2(NUM_REQ - 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic [NUM_REQ-1:0] ack,
    output logic               err
);

    localparam int BURST_W = macros::log_2(MAX_BURST);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REQ - 1);

    // Reject configurations the arbiter cannot implement.
    if (NUM_REQ < 2 || MAX_BURST < 1 || TIMEOUT < 2) begin : g_param_check
        $error("mem_port_arbiter: illegal parameter combination");
    end

    logic               state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q,   gnt_idx_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    logic               busy;
    logic               abort;
    logic               done;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    int                 cand;

    assign busy = (state_q == STATE_BUSY);

`ifdef ARB_TIMEOUT_EN
    localparam int WAIT_W = macros::log_2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Expiry fires only when no mem_ack is present, so a late ack still wins.
    always_comb begin
        abort = busy && !mem_ack && (wait_cnt_q == WAIT_LAST);
    end

    // Watchdog counts BUSY cycles since grant or since the last mem_ack.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!busy || mem_ack || abort) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign err = abort;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    // A transaction completes on mem_ack or on a watchdog abort.
    assign done = busy && (mem_ack || abort);

    // Round-robin search: the lowest offset from rr_ptr wins; descending
    // iteration lets the closest candidate overwrite farther ones.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (req[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Grant, burst and pointer sequencing for the IDLE/BUSY controller.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        burst_cnt_d = burst_cnt_q;
        if (state_q == STATE_IDLE) begin
            if (pick_valid) begin
                state_d     = STATE_BUSY;
                gnt_idx_d   = pick_idx;
                gnt_d       = {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick_idx;
                burst_cnt_d = '0;
            end
        end else if (done) begin
            if (!abort && lock[gnt_idx_q] && (burst_cnt_q < BURST_LAST)) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                state_d     = STATE_IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                burst_cnt_d = '0;
                rr_ptr_d    = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + 1'b1;
            end
        end
    end

    // Controller registers; reset drops any in-flight request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STATE_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign mem_req = busy;
    assign ack     = done ? gnt_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (NUM_REQ=3, MAX_BURST=4, TIMEOUT=8).
// A transaction-level reference model predicts each completion and each
// cycle's owner; a monitor compares DUT outputs against those predictions.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int MAX_BURST = 4;
    localparam int TIMEOUT   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ-1:0] lock = '0;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_idx;
    logic               mem_req;
    logic               mem_ack = 1'b0;
    logic [NUM_REQ-1:0] ack;
    logic               err;

    mem_port_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_BURST(MAX_BURST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .mem_req(mem_req),
        .mem_ack(mem_ack),
        .ack    (ack),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int   idx;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_log[$];
    int   ack_log[$];

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus controls.
    bit                 rand_mode   = 1'b0;
    bit                 rand_delay  = 1'b0;
    bit                 stray_ack   = 1'b0;
    bit                 mem_enable  = 1'b1;
    int                 fixed_delay = 0;
    int                 wait_left   = 0;
    logic [NUM_REQ-1:0] req_pattern  = '0;
    logic [NUM_REQ-1:0] lock_pattern = '0;
    logic [NUM_REQ-1:0] prev_ack  = '0;
    logic [NUM_REQ-1:0] prev_lock = '0;

    // Reference model: who owns the port, rotation pointer, burst and wait.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_burst = 0;
    int m_wait  = 0;

    function automatic bit modelAbort();
`ifdef ARB_TIMEOUT_EN
        return (m_owner >= 0) && !mem_ack && (m_wait == TIMEOUT - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model advances at each clock edge from the inputs held during the cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_burst = 0;
            m_wait  = 0;
            exp_q.delete();
        end else if (m_owner < 0) begin
            if (req != '0) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % NUM_REQ]) m_owner = (m_ptr + k) % NUM_REQ;
                end
                m_burst = 0;
                m_wait  = 0;
            end
        end else if (mem_ack || modelAbort()) begin
            if (mem_ack && lock[m_owner] && (m_burst < MAX_BURST - 1)) begin
                m_burst++;
                m_wait = 0;
            end else begin
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
            end
        end else begin
            m_wait++;
        end
    end

    // Predict the completion of the current cycle once inputs have settled.
    always begin
        @(negedge clk);
        #1;
        if (!rst && (m_owner >= 0) && (mem_ack || modelAbort())) begin
            exp_q.push_back('{idx: m_owner, err: !mem_ack});
        end
    end

    // Monitor: per-cycle grant state, and scoreboard pop on any ack/err.
    logic [NUM_REQ-1:0] mon_prev_gnt = '0;
    always begin
        logic [NUM_REQ-1:0] exp_gnt;
        logic [NUM_REQ-1:0] exp_ack;
        exp_t               e;
        @(negedge clk);
        #2;
        if (rst) begin
            mon_prev_gnt = '0;
        end else begin
            exp_gnt = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
            checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
            checkOutput("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            checkOutput("mem_req", 32'(mem_req), 32'(m_owner >= 0));
            if (gnt != mon_prev_gnt && gnt != '0) gnt_log.push_back(int'(gnt_idx));
            mon_prev_gnt = gnt;
            if (ack != '0 || err || exp_q.size() != 0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ack_err", {28'd0, err, ack}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    exp_ack = NUM_REQ'(1) << e.idx;
                    checkOutput("ack", 32'(ack), 32'(exp_ack));
                    checkOutput("err", 32'(err), 32'(e.err));
                    ack_log.push_back(e.idx);
                end
            end
        end
    end

    // One cycle of requester and memory behaviour, driven at the falling edge.
    task automatic applyStimulus(input int cycles);
        logic [NUM_REQ-1:0] drop;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            drop = prev_ack & ~prev_lock;
            req  = req & ~drop;
            if (rand_mode) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!req[i] && !drop[i] && ($urandom % 3 == 0)) req[i] = 1'b1;
                end
                lock = NUM_REQ'($urandom);
            end else begin
                req  = req | (req_pattern & ~drop);
                lock = lock_pattern;
            end
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && mem_enable) begin
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    wait_left = rand_delay ? int'($urandom % 4) : fixed_delay;
                end else begin
                    wait_left--;
                end
            end else if (!mem_req && stray_ack && ($urandom % 8 == 0)) begin
                mem_ack = 1'b1;
            end
            #3;
            prev_ack  = ack;
            prev_lock = lock;
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst          = 1'b1;
        req          = '0;
        lock         = '0;
        mem_ack      = 1'b0;
        req_pattern  = '0;
        lock_pattern = '0;
        prev_ack     = '0;
        prev_lock    = '0;
        wait_left    = fixed_delay;
        gnt_log.delete();
        ack_log.delete();
        #1;
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_ack_err", {28'd0, err, ack}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #(200000 * 10);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        rst = 1'b1;
        #1;
        checkOutput("por_gnt_idx", 32'(gnt_idx), 32'd0);
        rst = 1'b0;

        // Basic grant: one-cycle grant latency, ack on cycle 3, release on 4.
        fixed_delay = 2;
        resetDut();
        req_pattern = 3'b010;
        applyStimulus(2);
        checkOutput("basic_gnt", 32'(gnt), 32'h2);
        checkOutput("basic_gnt_idx", 32'(gnt_idx), 32'd1);
        checkOutput("basic_mem_req", 32'(mem_req), 32'd1);
        applyStimulus(2);
        checkOutput("basic_ack", 32'(ack), 32'h2);
        applyStimulus(1);
        checkOutput("basic_release", 32'(mem_req), 32'd0);

        // Wrap: after serving requester 1 the pointer sits at 2; only 0 asks.
        fixed_delay = 0;
        resetDut();
        req_pattern = 3'b010;
        applyStimulus(2);
        req_pattern = 3'b001;
        applyStimulus(2);
        checkOutput("wrap_gnt", 32'(gnt), 32'h1);
        checkOutput("wrap_gnt_idx", 32'(gnt_idx), 32'd0);

        // Round robin with all requesting: order 0,1,2,0,1.
        fixed_delay = 1;
        resetDut();
        req_pattern = 3'b111;
        applyStimulus(30);
        for (int i = 0; i < 5; i++) begin
            checkOutput("rr_order", (gnt_log.size() > i) ? 32'(gnt_log[i]) : 32'hFFFF, 32'(i % 3));
        end

        // Locked burst: four acks to requester 0 then requester 1.
        fixed_delay = 0;
        resetDut();
        req_pattern  = 3'b011;
        lock_pattern = 3'b001;
        applyStimulus(30);
        for (int i = 0; i < 5; i++) begin
            checkOutput("burst_acks", (ack_log.size() > i) ? 32'(ack_log[i]) : 32'hFFFF, (i < 4) ? 32'd0 : 32'd1);
        end
        checkOutput("burst_second_grant", (gnt_log.size() > 1) ? 32'(gnt_log[1]) : 32'hFFFF, 32'd1);

        // Reset mid-BUSY clears outputs asynchronously.
        resetDut();
        mem_enable  = 1'b0;
        req_pattern = 3'b010;
        applyStimulus(3);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        mem_ack = 1'b1;
        #1;
        checkOutput("async_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("async_rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("async_rst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        req         = '0;
        mem_ack     = 1'b0;
        req_pattern = '0;
        prev_ack    = '0;
        prev_lock   = '0;
        rst         = 1'b0;
        mem_enable  = 1'b1;
        applyStimulus(5);
        checkOutput("idle_gnt", 32'(gnt), 32'd0);
        checkOutput("idle_mem_req", 32'(mem_req), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // Timeout: requester 2 aborted on its 8th BUSY cycle, then 0 served.
        resetDut();
        mem_enable  = 1'b0;
        req_pattern = 3'b100;
        for (int c = 1; c <= 11; c++) begin
            if (c == 4) req_pattern = 3'b101;
            applyStimulus(1);
            if (c == 9) begin
                checkOutput("timeout_err", 32'(err), 32'd1);
                checkOutput("timeout_ack", 32'(ack), 32'h4);
            end
            if (c == 11) checkOutput("timeout_next_gnt", 32'(gnt), 32'h1);
        end
        mem_enable = 1'b1;
`else
        // No watchdog: silent memory keeps the grant indefinitely.
        resetDut();
        mem_enable  = 1'b0;
        req_pattern = 3'b010;
        applyStimulus(100);
        checkOutput("hold_gnt", 32'(gnt), 32'h2);
        checkOutput("hold_err", 32'(err), 32'd0);
        mem_enable = 1'b1;
`endif

        // Randomized traffic with random latencies, locks and stray acks.
        resetDut();
        rand_mode  = 1'b1;
        rand_delay = 1'b1;
        stray_ack  = 1'b1;
        applyStimulus(3000);
        rand_mode    = 1'b0;
        stray_ack    = 1'b0;
        req_pattern  = '0;
        lock_pattern = '0;
        applyStimulus(60);
        checkOutput("drain_idle", {29'd0, mem_req, 2'd0} | 32'(gnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
